// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares one downstream memory port between an instruction requester and a
//    data (load/store) requester. Each requester owns a one-deep pending slot;
//    an idle arbiter issues one slot's request to memory, waits for the
//    response, forwards it to the owning port, then frees that slot. Only one
//    downstream transaction is ever outstanding.
//
//    Configuration macro: ARB_ROUND_ROBIN_EN
//       defined   -> ties go to the port not granted last (instruction wins
//                    the first tie after reset)
//       undefined -> fixed priority, data wins every tie
//
//    Ports
//       clk       in   clock, rising edge
//       reset     in   synchronous, active-high
//       inst_req  in   instruction request
//       inst_rsp  out  instruction response data/valid, ready = slot empty
//       data_req  in   data request
//       data_rsp  out  data response data/valid, ready = slot empty
//       mem_req   out  shared downstream request (all zero when not issuing)
//       mem_rsp   in   downstream response (valid, data, ready)

package memory_io_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  do_read;
      logic [3:0]  do_write;
      logic        valid;
   } memory_io_req;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic        ready;
   } memory_io_rsp;

   localparam memory_io_req memory_io_no_req32 = '0;
endpackage

module mem_port_arbiter
   import memory_io_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  memory_io_req inst_req,
   output memory_io_rsp inst_rsp,
   input  memory_io_req data_req,
   output memory_io_rsp data_rsp,
   output memory_io_req mem_req,
   input  memory_io_rsp mem_rsp
);

   typedef enum logic [1:0] {IDLE, WAIT_INST, WAIT_DATA} state_t;

   state_t       state_reg;
   memory_io_req inst_slot_reg;
   memory_io_req data_slot_reg;
   logic         inst_full_reg;
   logic         data_full_reg;

   logic tie_to_data;
   logic grant_data;
   logic issue;
   logic rsp_fire;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data was granted last; reset value makes instruction win the first tie
   logic last_grant_data_reg;
   assign tie_to_data = ~last_grant_data_reg;
`else
   assign tie_to_data = 1'b1;
`endif

   assign grant_data = data_full_reg & (~inst_full_reg | tie_to_data);

   // Issue and response are decided combinationally in the cycle they happen;
   // reset masks both so nothing leaks out during the reset cycle.
   assign issue    = ~reset & (state_reg == IDLE) & mem_rsp.ready
                   & (inst_full_reg | data_full_reg);
   assign rsp_fire = ~reset & (state_reg != IDLE) & mem_rsp.valid;

   always_comb begin
      mem_req = memory_io_no_req32;
      if (issue) begin
         mem_req       = grant_data ? data_slot_reg : inst_slot_reg;
         mem_req.valid = 1'b1;
      end

      inst_rsp       = '0;
      inst_rsp.ready = ~inst_full_reg;
      if (rsp_fire && state_reg == WAIT_INST) begin
         inst_rsp.valid = 1'b1;
         inst_rsp.data  = mem_rsp.data;
      end

      data_rsp       = '0;
      data_rsp.ready = ~data_full_reg;
      if (rsp_fire && state_reg == WAIT_DATA) begin
         data_rsp.valid = 1'b1;
         data_rsp.data  = mem_rsp.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         inst_slot_reg <= memory_io_no_req32;
         data_slot_reg <= memory_io_no_req32;
         inst_full_reg <= 1'b0;
         data_full_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_data_reg <= 1'b1;
`endif
      end else begin
         // Capture only into an empty slot; a slot is only cleared while full,
         // so capture and clear never target the same slot on one edge.
         if (inst_req.valid && !inst_full_reg) begin
            inst_slot_reg <= inst_req;
            inst_full_reg <= 1'b1;
         end
         if (data_req.valid && !data_full_reg) begin
            data_slot_reg <= data_req;
            data_full_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (issue) begin
                  state_reg <= grant_data ? WAIT_DATA : WAIT_INST;
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant_data_reg <= grant_data;
`endif
               end
            end
            WAIT_INST: begin
               if (mem_rsp.valid) begin
                  inst_full_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            WAIT_DATA: begin
               if (mem_rsp.valid) begin
                  data_full_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run compared cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
   import memory_io_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   memory_io_req inst_req, data_req, mem_req;
   memory_io_rsp inst_rsp, data_rsp, mem_rsp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .inst_req (inst_req),
      .inst_rsp (inst_rsp),
      .data_req (data_req),
      .data_rsp (data_rsp),
      .mem_req  (mem_req),
      .mem_rsp  (mem_rsp)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req      = '0;
      data_req      = '0;
      mem_rsp       = '0;
      mem_rsp.ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   function automatic memory_io_req mk_req(logic [31:0] a, logic [31:0] d,
                                           logic [3:0] rd, logic [3:0] wr);
      memory_io_req r;
      r.addr = a; r.data = d; r.do_read = rd; r.do_write = wr; r.valid = 1'b1;
      return r;
   endfunction

   task automatic test_reset();
      idle_inputs();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'hAAAA5555;
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      if (mem_req.valid !== 1'b0) begin $display("FAIL reset_mem_valid: got %b expected 0", mem_req.valid); n_fail++; end n_checks++;
      if (inst_rsp !== 34'h1) begin $display("FAIL reset_inst_rsp: got %h expected 1 (ready only)", inst_rsp); n_fail++; end n_checks++;
      if (data_rsp !== 34'h1) begin $display("FAIL reset_data_rsp: got %h expected 1 (ready only)", data_rsp); n_fail++; end n_checks++;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      // response in IDLE is dropped
      if (inst_rsp.valid !== 1'b0 || data_rsp.valid !== 1'b0) begin
         $display("FAIL idle_rsp_drop: got inst %b data %b expected 0 0", inst_rsp.valid, data_rsp.valid); n_fail++; end n_checks++;
      if (mem_req !== memory_io_no_req32) begin $display("FAIL idle_no_req: got %h expected 0", mem_req); n_fail++; end n_checks++;
      next_cycle();
   endtask

   task automatic test_single_fetch();
      do_reset();
      inst_req = mk_req(32'h100, 32'h0, 4'b1111, 4'b0000);
      @(negedge clk);
      if (inst_rsp.ready !== 1'b1) begin $display("FAIL fetch_ready_before: got %b expected 1", inst_rsp.ready); n_fail++; end n_checks++;
      next_cycle();
      inst_req = '0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h100 || mem_req.do_read !== 4'hF) begin
         $display("FAIL fetch_issue: got valid %b addr %h rd %h expected 1 00000100 f", mem_req.valid, mem_req.addr, mem_req.do_read); n_fail++; end n_checks++;
      if (inst_rsp.ready !== 1'b0) begin $display("FAIL fetch_ready_busy: got %b expected 0", inst_rsp.ready); n_fail++; end n_checks++;
      next_cycle();
      @(negedge clk);
      if (mem_req.valid !== 1'b0) begin $display("FAIL fetch_single_issue: got %b expected 0", mem_req.valid); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'hDEADBEEF;
      @(negedge clk);
      if (inst_rsp.valid !== 1'b1 || inst_rsp.data !== 32'hDEADBEEF) begin
         $display("FAIL fetch_rsp: got valid %b data %h expected 1 deadbeef", inst_rsp.valid, inst_rsp.data); n_fail++; end n_checks++;
      if (data_rsp.valid !== 1'b0 || data_rsp.data !== 32'h0) begin
         $display("FAIL fetch_other_port: got valid %b data %h expected 0 0", data_rsp.valid, data_rsp.data); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
      @(negedge clk);
      if (inst_rsp.ready !== 1'b1 || inst_rsp.valid !== 1'b0) begin
         $display("FAIL fetch_ready_after: got ready %b valid %b expected 1 0", inst_rsp.ready, inst_rsp.valid); n_fail++; end n_checks++;
      next_cycle();
   endtask

   task automatic test_tie();
      logic [31:0] first_addr, second_addr;
      bit          first_is_inst;
      first_is_inst = RR_EN;
      first_addr    = first_is_inst ? 32'h200 : 32'h8000;
      second_addr   = first_is_inst ? 32'h8000 : 32'h200;
      do_reset();
      inst_req = mk_req(32'h200, 32'h0, 4'b1111, 4'b0000);
      data_req = mk_req(32'h8000, 32'h12345678, 4'b0000, 4'b0011);
      next_cycle();
      inst_req = '0;
      data_req = '0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== first_addr) begin
         $display("FAIL tie_first_issue: got valid %b addr %h expected 1 %h", mem_req.valid, mem_req.addr, first_addr); n_fail++; end n_checks++;
      if (!first_is_inst && (mem_req.data !== 32'h12345678 || mem_req.do_write !== 4'b0011)) begin
         $display("FAIL tie_store_fields: got data %h wr %b expected 12345678 0011", mem_req.data, mem_req.do_write); n_fail++; end
      if (inst_rsp.ready !== 1'b0 || data_rsp.ready !== 1'b0) begin
         $display("FAIL tie_both_captured: got ready %b %b expected 0 0", inst_rsp.ready, data_rsp.ready); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'h11111111;
      @(negedge clk);
      if ((first_is_inst ? inst_rsp.valid : data_rsp.valid) !== 1'b1) begin
         $display("FAIL tie_first_rsp: got inst %b data %b expected first port only", inst_rsp.valid, data_rsp.valid); n_fail++; end n_checks++;
      if ((first_is_inst ? data_rsp.valid : inst_rsp.valid) !== 1'b0) begin
         $display("FAIL tie_first_rsp_other: got inst %b data %b expected first port only", inst_rsp.valid, data_rsp.valid); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== second_addr) begin
         $display("FAIL tie_second_issue: got valid %b addr %h expected 1 %h", mem_req.valid, mem_req.addr, second_addr); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'h22222222;
      @(negedge clk);
      if ((first_is_inst ? data_rsp.data : inst_rsp.data) !== 32'h22222222) begin
         $display("FAIL tie_second_rsp: got inst %h data %h expected 22222222 on second port", inst_rsp.data, data_rsp.data); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
      @(negedge clk);
      if (inst_rsp.ready !== 1'b1 || data_rsp.ready !== 1'b1) begin
         $display("FAIL tie_done_ready: got %b %b expected 1 1", inst_rsp.ready, data_rsp.ready); n_fail++; end n_checks++;
      next_cycle();
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_rsp.ready = 1'b0;
      inst_req = mk_req(32'h500, 32'h0, 4'b1111, 4'b0000);
      next_cycle();
      inst_req = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_req.valid !== 1'b0 || inst_rsp.ready !== 1'b0) begin
            $display("FAIL backpressure_hold_%0d: got valid %b ready %b expected 0 0", k, mem_req.valid, inst_rsp.ready); n_fail++; end n_checks++;
         next_cycle();
      end
      mem_rsp.ready = 1'b1;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h500) begin
         $display("FAIL backpressure_release: got valid %b addr %h expected 1 00000500", mem_req.valid, mem_req.addr); n_fail++; end n_checks++;
      next_cycle();
   endtask

   task automatic test_pulse_during_wait();
      do_reset();
      inst_req = mk_req(32'h600, 32'h0, 4'b1111, 4'b0000);
      next_cycle();
      inst_req = '0;
      next_cycle();
      data_req = mk_req(32'h3000, 32'h0, 4'b1111, 4'b0000);
      @(negedge clk);
      if (mem_req.valid !== 1'b0) begin $display("FAIL pulse_no_issue_in_wait: got %b expected 0", mem_req.valid); n_fail++; end n_checks++;
      next_cycle();
      data_req = '0;
      @(negedge clk);
      if (data_rsp.ready !== 1'b0) begin $display("FAIL pulse_captured: got ready %b expected 0", data_rsp.ready); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'h55555555;
      @(negedge clk);
      if (inst_rsp.valid !== 1'b1 || data_rsp.valid !== 1'b0) begin
         $display("FAIL pulse_inst_rsp: got inst %b data %b expected 1 0", inst_rsp.valid, data_rsp.valid); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h3000) begin
         $display("FAIL pulse_data_issue: got valid %b addr %h expected 1 00003000", mem_req.valid, mem_req.addr); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'h77777777;
      @(negedge clk);
      if (data_rsp.valid !== 1'b1 || data_rsp.data !== 32'h77777777 || inst_rsp.valid !== 1'b0) begin
         $display("FAIL pulse_data_rsp: got valid %b data %h inst %b expected 1 77777777 0", data_rsp.valid, data_rsp.data, inst_rsp.valid); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      data_req = mk_req(32'h8800, 32'hAB, 4'b0000, 4'b1111);
      next_cycle();
      data_req = '0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1) begin $display("FAIL rstwait_issue: got %b expected 1", mem_req.valid); n_fail++; end n_checks++;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      if (mem_req.valid !== 1'b0 || data_rsp.valid !== 1'b0) begin
         $display("FAIL rstwait_during_reset: got mem %b data %b expected 0 0", mem_req.valid, data_rsp.valid); n_fail++; end n_checks++;
      next_cycle();
      reset = 1'b0;
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'hCAFEF00D;
      @(negedge clk);
      if (inst_rsp !== 34'h1 || data_rsp !== 34'h1) begin
         $display("FAIL rstwait_drop: got inst %h data %h expected 1 1 (ready only)", inst_rsp, data_rsp); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
      inst_req = mk_req(32'h700, 32'h0, 4'b1111, 4'b0000);
      next_cycle();
      inst_req = '0;
      @(negedge clk);
      if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h700) begin
         $display("FAIL rstwait_next_issue: got valid %b addr %h expected 1 00000700", mem_req.valid, mem_req.addr); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b1;
      mem_rsp.data  = 32'h00001234;
      @(negedge clk);
      if (inst_rsp.valid !== 1'b1 || inst_rsp.data !== 32'h00001234) begin
         $display("FAIL rstwait_next_rsp: got valid %b data %h expected 1 00001234", inst_rsp.valid, inst_rsp.data); n_fail++; end n_checks++;
      next_cycle();
      mem_rsp.valid = 1'b0;
   endtask

   // Both ports valid continuously; the grant sequence must alternate.
   task automatic test_back_to_back();
      int grants[$];
      int cycles;
      bit pend;
      do_reset();
      inst_req = mk_req(32'h400, 32'h0, 4'b1111, 4'b0000);
      data_req = mk_req(32'h9000, 32'h5A5A5A5A, 4'b0000, 4'b1111);
      pend   = 1'b0;
      cycles = 0;
      while (grants.size() < 8 && cycles < 200) begin
         mem_rsp.valid = pend;
         mem_rsp.data  = $urandom;
         @(negedge clk);
         pend = 1'b0;
         if (mem_req.valid) begin
            grants.push_back((mem_req.addr == 32'h9000) ? 1 : 0);
            pend = 1'b1;
         end
         next_cycle();
         cycles++;
      end
      if (grants.size() != 8) begin $display("FAIL b2b_timeout: got %0d grants expected 8", grants.size()); n_fail++; end n_checks++;
      for (int k = 0; k < grants.size(); k++) begin
         int exp_g;
         exp_g = (RR_EN ? 0 : 1) ^ (k % 2);
         $display("b2b grant %0d: port %0s", k, grants[k] ? "data" : "inst");
         if (grants[k] != exp_g) begin $display("FAIL b2b_grant_%0d: got %0d expected %0d (0=inst 1=data)", k, grants[k], exp_g); n_fail++; end n_checks++;
      end
      idle_inputs();
   endtask

   // Randomized traffic against a transaction-level model: two pending
   // slots, an owner of the outstanding transaction, and the tie rule.
   task automatic test_random();
      bit           m_full[2];
      memory_io_req m_slot[2];
      memory_io_req cur[2];
      int           m_owner;   // 0 none, 1 inst, 2 data
      bit           m_last_data;
      memory_io_req e_mem;
      memory_io_rsp e_rsp[2];
      bit           iss, fire;
      bit           cap[2];
      int           w;
      do_reset();
      m_full = '{0, 0};
      m_owner = 0;
      m_last_data = 1'b1;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         cur[0] = mk_req($urandom, $urandom, 4'($urandom), 4'($urandom));
         cur[1] = mk_req($urandom, $urandom, 4'($urandom), 4'($urandom));
         cur[0].valid = ($urandom_range(0, 2) == 0);
         cur[1].valid = ($urandom_range(0, 2) == 0);
         inst_req = cur[0];
         data_req = cur[1];
         mem_rsp.valid = ($urandom_range(0, 2) == 0);
         mem_rsp.ready = ($urandom_range(0, 3) != 0);
         mem_rsp.data  = $urandom;
         @(negedge clk);

         e_mem = memory_io_no_req32;
         for (int p = 0; p < 2; p++) begin
            e_rsp[p] = '0;
            e_rsp[p].ready = !m_full[p];
         end
         if (m_full[0] && m_full[1]) w = RR_EN ? (m_last_data ? 0 : 1) : 1;
         else                        w = m_full[1] ? 1 : 0;
         iss  = !reset && m_owner == 0 && mem_rsp.ready && (m_full[0] || m_full[1]);
         fire = !reset && m_owner != 0 && mem_rsp.valid;
         if (iss) begin
            e_mem = m_slot[w];
            e_mem.valid = 1'b1;
         end
         if (fire) begin
            e_rsp[m_owner-1].valid = 1'b1;
            e_rsp[m_owner-1].data  = mem_rsp.data;
         end
         if (mem_req !== e_mem) begin $display("FAIL rand_mem_req cyc %0d: got %h expected %h", i, mem_req, e_mem); n_fail++; end n_checks++;
         if (inst_rsp !== e_rsp[0]) begin $display("FAIL rand_inst_rsp cyc %0d: got %h expected %h", i, inst_rsp, e_rsp[0]); n_fail++; end n_checks++;
         if (data_rsp !== e_rsp[1]) begin $display("FAIL rand_data_rsp cyc %0d: got %h expected %h", i, data_rsp, e_rsp[1]); n_fail++; end n_checks++;

         if (reset) begin
            m_full = '{0, 0};
            m_owner = 0;
            m_last_data = 1'b1;
         end else begin
            for (int p = 0; p < 2; p++) cap[p] = cur[p].valid && !m_full[p];
            if (fire) begin
               m_full[m_owner-1] = 1'b0;
               m_owner = 0;
            end
            if (iss) begin
               m_owner = w + 1;
               m_last_data = (w == 1);
            end
            for (int p = 0; p < 2; p++) if (cap[p]) begin
               m_full[p] = 1'b1;
               m_slot[p] = cur[p];
            end
         end
         next_cycle();
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_fetch();
      test_tie();
      test_backpressure();
      test_pulse_during_wait();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
